// File: rtl/seq_detect_fsm.sv
// rtl/seq_detect_fsm.sv - parametrised serial pattern detector with match counter
//
// Samples one bit of x on each enabled clock and flags completion of a
// PAT_LEN-bit PATTERN (PATTERN[PAT_LEN-1] is the first bit received).
//
// Parameters:
//   PAT_LEN  pattern length in bits (2..32)
//   PATTERN  pattern to detect
//   OVERLAP  1: the tail of one match may begin the next; 0: restart after a match
//   STICKY   0: z pulses for one cycle per match; 1: z latches high until clear/reset
//   CNT_W    width of the saturating match counter
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   clear      in   synchronous clear of all state, wins over en
//   en         in   sample x this cycle
//   x          in   serial data bit
//   z          out  registered match flag
//   match_cnt  out  matches since reset/clear, saturating at all-ones
//   cnt_sat    out  match_cnt is all-ones
//   fill       out  number of valid history bits, 0..PAT_LEN

module seq_detect_fsm #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter bit                 OVERLAP = 1'b1,
  parameter bit                 STICKY  = 1'b0,
  parameter int                 CNT_W   = 8,
  localparam int                FILL_W  = $clog2(PAT_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              en,
  input  logic              x,
  output logic              z,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              cnt_sat,
  output logic [FILL_W-1:0] fill
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  // Sticky lock: only ever leaves DETECT when STICKY is set.
  typedef enum logic {
    DETECT = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  lock_state_t        lock_q, lock_d;
  logic [PAT_LEN-1:0] hist, hist_d, hist_shift;
  logic [FILL_W-1:0]  fill_d, fill_inc;
  logic [CNT_W-1:0]   cnt_d;
  logic               z_d, sat_d, match;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
      z         <= 1'b0;
      lock_q    <= DETECT;
    end else begin
      hist      <= hist_d;
      fill      <= fill_d;
      match_cnt <= cnt_d;
      cnt_sat   <= sat_d;
      z         <= z_d;
      lock_q    <= lock_d;
    end
  end

  always_comb begin
    hist_shift = {hist[PAT_LEN-2:0], x};
    fill_inc   = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    match      = 1'b0;
    hist_d     = hist;
    fill_d     = fill;
    cnt_d      = match_cnt;
    lock_d     = lock_q;
    z_d        = 1'b0;

    if (clear) begin
      // The bit presented alongside clear is dropped, so no match can occur.
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
      lock_d = DETECT;
    end else begin
      if (en) begin
        hist_d = hist_shift;
        fill_d = fill_inc;
        // fill guard keeps the zero-filled history from matching early.
        match  = (fill_inc == FILL_FULL) && (hist_shift == PATTERN);
        if (match) begin
          if (match_cnt != CNT_MAX) begin
            cnt_d = match_cnt + CNT_W'(1);
          end
          if (!OVERLAP) begin
            hist_d = '0;
            fill_d = '0;
          end
        end
      end

      if (STICKY) begin
        z_d = (lock_q == LOCKED) || match;
        if (match) begin
          lock_d = LOCKED;
        end
      end else begin
        z_d = match;
      end
    end

    sat_d = (cnt_d == CNT_MAX);
  end

endmodule

// File: tb/tb_seq_detect_fsm.sv
// tb/tb_seq_detect_fsm.sv - randomized and directed bench for seq_detect_fsm

module tb_seq_detect_fsm;

  localparam int NI = 5;

  logic clk, reset_n, clear, en, x;

  logic       z_o    [NI];
  logic [7:0] cnt_o  [NI];
  logic       sat_o  [NI];
  logic [2:0] fill_o [NI];

  logic [7:0] c0, c1, c2, c4;
  logic [1:0] c3;
  logic [2:0] f0, f1, f2, f3, f4;
  logic       z0, z1, z2, z3, z4, s0, s1, s2, s3, s4;

  // inst0 defaults, inst1 non-overlap, inst2 sticky, inst3 2-bit counter, inst4 5-bit pattern
  seq_detect_fsm u0 (.clk(clk), .reset_n(reset_n), .clear(clear), .en(en), .x(x),
                     .z(z0), .match_cnt(c0), .cnt_sat(s0), .fill(f0));
  seq_detect_fsm #(.OVERLAP(1'b0)) u1 (.clk(clk), .reset_n(reset_n), .clear(clear), .en(en), .x(x),
                     .z(z1), .match_cnt(c1), .cnt_sat(s1), .fill(f1));
  seq_detect_fsm #(.STICKY(1'b1)) u2 (.clk(clk), .reset_n(reset_n), .clear(clear), .en(en), .x(x),
                     .z(z2), .match_cnt(c2), .cnt_sat(s2), .fill(f2));
  seq_detect_fsm #(.CNT_W(2)) u3 (.clk(clk), .reset_n(reset_n), .clear(clear), .en(en), .x(x),
                     .z(z3), .match_cnt(c3), .cnt_sat(s3), .fill(f3));
  seq_detect_fsm #(.PAT_LEN(5), .PATTERN(5'b10011)) u4 (.clk(clk), .reset_n(reset_n), .clear(clear),
                     .en(en), .x(x), .z(z4), .match_cnt(c4), .cnt_sat(s4), .fill(f4));

  assign z_o[0] = z0;  assign cnt_o[0] = c0;           assign sat_o[0] = s0;  assign fill_o[0] = f0;
  assign z_o[1] = z1;  assign cnt_o[1] = c1;           assign sat_o[1] = s1;  assign fill_o[1] = f1;
  assign z_o[2] = z2;  assign cnt_o[2] = c2;           assign sat_o[2] = s2;  assign fill_o[2] = f2;
  assign z_o[3] = z3;  assign cnt_o[3] = {6'b0, c3};   assign sat_o[3] = s3;  assign fill_o[3] = f3;
  assign z_o[4] = z4;  assign cnt_o[4] = c4;           assign sat_o[4] = s4;  assign fill_o[4] = f4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: each instance keeps the list of bits received since the last restart.
  int p_len [NI];
  int p_pat [NI];
  int p_ovl [NI];
  int p_stk [NI];
  int p_max [NI];
  int mbuf  [NI][32];
  int m_len [NI];
  int m_cnt [NI];
  int m_lock[NI];
  int m_z   [NI];
  int m_sat [NI];

  task automatic model_init();
    p_len = '{4, 4, 4, 4, 5};
    p_pat = '{13, 13, 13, 13, 19};
    p_ovl = '{1, 0, 1, 1, 1};
    p_stk = '{0, 0, 1, 0, 0};
    p_max = '{255, 255, 255, 3, 255};
    for (int k = 0; k < NI; k++) begin
      m_len[k] = 0; m_cnt[k] = 0; m_lock[k] = 0; m_z[k] = 0; m_sat[k] = 0;
    end
  endtask

  task automatic model_update(input logic xi, input logic ei, input logic ci);
    for (int k = 0; k < NI; k++) begin
      int hit;
      hit = 0;
      if (ci) begin
        m_len[k] = 0; m_cnt[k] = 0; m_lock[k] = 0; m_z[k] = 0;
      end else begin
        if (ei) begin
          if (m_len[k] == p_len[k]) begin
            for (int i = 0; i < p_len[k] - 1; i++) mbuf[k][i] = mbuf[k][i+1];
            mbuf[k][p_len[k]-1] = int'(xi);
          end else begin
            mbuf[k][m_len[k]] = int'(xi);
            m_len[k]++;
          end
          if (m_len[k] == p_len[k]) begin
            hit = 1;
            for (int i = 0; i < p_len[k]; i++)
              if (mbuf[k][i] != ((p_pat[k] >> (p_len[k] - 1 - i)) & 1)) hit = 0;
          end
        end
        if (hit != 0) begin
          if (m_cnt[k] < p_max[k]) m_cnt[k]++;
          if (p_ovl[k] == 0) m_len[k] = 0;
        end
        m_z[k] = (p_stk[k] != 0) ? (m_lock[k] | hit) : hit;
        if (p_stk[k] != 0 && hit != 0) m_lock[k] = 1;
      end
      m_sat[k] = (m_cnt[k] == p_max[k]) ? 1 : 0;
    end
  endtask

  task automatic step(input logic xi, input logic ei, input logic ci);
    x = xi; en = ei; clear = ci;
    @(posedge clk);
    model_update(xi, ei, ci);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; x = 1'b0; en = 1'b0; clear = 1'b0;
    model_init();
    #12;
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (z_o[k] !== 1'b0 || cnt_o[k] !== 8'd0 || sat_o[k] !== 1'b0 || fill_o[k] !== 3'd0)
        $display("FAIL reset inst%0d: got z=%b cnt=%0d sat=%b fill=%0d, want all 0",
                 k, z_o[k], cnt_o[k], sat_o[k], fill_o[k]);
      else n_pass++;
    end
    #1 reset_n = 1'b1;
  endtask

  task automatic test_overlap();
    logic [6:0] s;
    logic [6:0] zexp;
    s    = 7'b1101101;
    zexp = 7'b0001001;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(s[6-i], 1'b1, 1'b0);
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (z_o[k] !== m_z[k][0] || cnt_o[k] !== 8'(m_cnt[k]) || sat_o[k] !== m_sat[k][0] || fill_o[k] !== 3'(m_len[k]))
          $display("FAIL overlap inst%0d bit%0d: got z=%b cnt=%0d sat=%b fill=%0d want z=%0d cnt=%0d sat=%0d fill=%0d",
                   k, i, z_o[k], cnt_o[k], sat_o[k], fill_o[k], m_z[k], m_cnt[k], m_sat[k], m_len[k]);
        else n_pass++;
      end
      n_checks++;
      if (z_o[0] !== zexp[6-i]) $display("FAIL overlap_z bit%0d: got %b want %b", i, z_o[0], zexp[6-i]);
      else n_pass++;
    end
    n_checks++;
    if (cnt_o[0] !== 8'd2) $display("FAIL overlap_cnt: got %0d want 2", cnt_o[0]);
    else n_pass++;
  endtask

  task automatic test_non_overlap();
    logic [10:0] s;
    s = 11'b11011011101;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      step(s[10-i], 1'b1, 1'b0);
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (z_o[k] !== m_z[k][0] || cnt_o[k] !== 8'(m_cnt[k]) || sat_o[k] !== m_sat[k][0] || fill_o[k] !== 3'(m_len[k]))
          $display("FAIL non_overlap inst%0d bit%0d: got z=%b cnt=%0d fill=%0d want z=%0d cnt=%0d fill=%0d",
                   k, i, z_o[k], cnt_o[k], fill_o[k], m_z[k], m_cnt[k], m_len[k]);
        else n_pass++;
      end
      if (i == 6) begin
        n_checks++;
        if (cnt_o[1] !== 8'd1 || z_o[1] !== 1'b0) $display("FAIL non_overlap_bit7: got cnt=%0d z=%b want cnt=1 z=0", cnt_o[1], z_o[1]);
        else n_pass++;
      end
    end
    n_checks++;
    if (cnt_o[1] !== 8'd2 || z_o[1] !== 1'b1) $display("FAIL non_overlap_end: got cnt=%0d z=%b want cnt=2 z=1", cnt_o[1], z_o[1]);
    else n_pass++;
  endtask

  task automatic test_sticky();
    logic [8:0] s;
    s = 9'b110100000;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(s[8-i], 1'b1, 1'b0);
      n_checks++;
      if (z_o[2] !== m_z[2][0] || cnt_o[2] !== 8'(m_cnt[2]) || z_o[0] !== m_z[0][0])
        $display("FAIL sticky bit%0d: got z2=%b cnt2=%0d z0=%b want z2=%0d cnt2=%0d z0=%0d",
                 i, z_o[2], cnt_o[2], z_o[0], m_z[2], m_cnt[2], m_z[0]);
      else n_pass++;
      if (i >= 3) begin
        n_checks++;
        if (z_o[2] !== 1'b1) $display("FAIL sticky_hold bit%0d: got %b want 1", i, z_o[2]);
        else n_pass++;
      end
    end
    step(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (z_o[2] !== 1'b0 || cnt_o[2] !== 8'd0) $display("FAIL sticky_clear: got z=%b cnt=%0d want 0 0", z_o[2], cnt_o[2]);
    else n_pass++;
  endtask

  task automatic test_en_gap();
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (fill_o[0] !== 3'd2 || z_o[0] !== 1'b0 || fill_o[0] !== 3'(m_len[0]))
        $display("FAIL en_gap_hold cyc%0d: got fill=%0d z=%b want fill=2 z=0", i, fill_o[0], z_o[0]);
      else n_pass++;
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (z_o[0] !== 1'b1 || cnt_o[0] !== 8'd1 || z_o[0] !== m_z[0][0])
      $display("FAIL en_gap_match: got z=%b cnt=%0d want z=1 cnt=1", z_o[0], cnt_o[0]);
    else n_pass++;
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (z_o[0] !== 1'b0) $display("FAIL en_gap_pulse: got z=%b want 0", z_o[0]);
    else n_pass++;
  endtask

  task automatic test_saturation();
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    for (int r = 0; r < 5; r++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (z_o[3] !== 1'b1 || cnt_o[3] !== 8'(m_cnt[3]) || sat_o[3] !== m_sat[3][0])
        $display("FAIL saturation match%0d: got z=%b cnt=%0d sat=%b want z=1 cnt=%0d sat=%0d",
                 r + 1, z_o[3], cnt_o[3], sat_o[3], m_cnt[3], m_sat[3]);
      else n_pass++;
    end
    n_checks++;
    if (cnt_o[3] !== 8'd3 || sat_o[3] !== 1'b1 || cnt_o[0] !== 8'd5 || sat_o[0] !== 1'b0)
      $display("FAIL saturation_end: got cnt3=%0d sat3=%b cnt0=%0d sat0=%b want 3 1 5 0",
               cnt_o[3], sat_o[3], cnt_o[0], sat_o[0]);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    model_update(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (z_o[k] !== 1'b0 || cnt_o[k] !== 8'd0 || sat_o[k] !== 1'b0 || fill_o[k] !== 3'd0)
        $display("FAIL async_reset inst%0d: got z=%b cnt=%0d sat=%b fill=%0d want all 0",
                 k, z_o[k], cnt_o[k], sat_o[k], fill_o[k]);
      else n_pass++;
    end
    #1 reset_n = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (z_o[0] !== 1'b0 || fill_o[0] !== 3'd1 || cnt_o[0] !== 8'd0)
      $display("FAIL async_reset_restart: got z=%b fill=%0d cnt=%0d want 0 1 0", z_o[0], fill_o[0], cnt_o[0]);
    else n_pass++;
  endtask

  task automatic test_clear_last_bit();
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (z_o[0] !== 1'b0 || cnt_o[0] !== 8'd0 || fill_o[0] !== 3'd0 || z_o[2] !== 1'b0)
      $display("FAIL clear_last_bit: got z=%b cnt=%0d fill=%0d z2=%b want 0 0 0 0",
               z_o[0], cnt_o[0], fill_o[0], z_o[2]);
    else n_pass++;
  endtask

  task automatic test_random();
    logic xi, ei, ci;
    for (int n = 0; n < 1500; n++) begin
      xi = 1'($urandom_range(0, 1));
      ei = ($urandom_range(0, 9) < 8);
      ci = ($urandom_range(0, 99) == 0);
      step(xi, ei, ci);
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (z_o[k] !== m_z[k][0] || cnt_o[k] !== 8'(m_cnt[k]) || sat_o[k] !== m_sat[k][0] || fill_o[k] !== 3'(m_len[k]))
          $display("FAIL random inst%0d cyc%0d: got z=%b cnt=%0d sat=%b fill=%0d want z=%0d cnt=%0d sat=%0d fill=%0d",
                   k, n, z_o[k], cnt_o[k], sat_o[k], fill_o[k], m_z[k], m_cnt[k], m_sat[k], m_len[k]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_sticky();
    test_en_gap();
    test_saturation();
    test_async_reset();
    test_clear_last_bit();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
